// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared constants and TX state encoding for the SPART
//                controller, receiver and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    // Baud divisor width and the divisor used after reset:
    // 50 MHz / (16 x 9600) = 325.
    localparam int unsigned         c_DIV_W       = 16;
    localparam logic [c_DIV_W-1:0]  c_DEFAULT_DIV = 16'd325;

    // TX handshake states, encoded explicitly in two bits.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_t;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spart_baud_gen
//  Description : Programmable 16x-oversampling tick generator. A new divisor
//                is parked in a pending register and only takes effect while
//                the TX side reports idle, restarting the count from zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int unsigned      DIV_W       = c_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(c_DEFAULT_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cfg_wr,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_idle,
    output logic             o_cfg_pend,
    output logic             o_enable
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] r_bcnt;
    logic             r_cfg_pend;
    logic             r_enable;
    logic             w_apply;
    logic [DIV_W-1:0] w_last;

    // A divisor of zero is treated as one, so the terminal count is zero.
    assign w_last  = (r_div == '0) ? '0 : (r_div - DIV_W'(1));
    assign w_apply = r_cfg_pend & i_idle;

    // Divisor/pending registers, counter and registered tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= DEFAULT_DIV;
            r_pend_div <= DEFAULT_DIV;
            r_cfg_pend <= 1'b0;
            r_bcnt     <= '0;
            r_enable   <= 1'b0;
        end else begin
            r_enable <= (r_bcnt == w_last);

            if (w_apply) begin
                r_div  <= r_pend_div;
                r_bcnt <= '0;
            end else if (r_bcnt >= w_last) begin
                r_bcnt <= '0;
            end else begin
                r_bcnt <= r_bcnt + DIV_W'(1);
            end

            // A write in the apply cycle keeps the flag set for the new value.
            if (i_cfg_wr) begin
                r_pend_div <= i_cfg_div;
                r_cfg_pend <= 1'b1;
            end else if (w_apply) begin
                r_cfg_pend <= 1'b0;
            end
        end
    end

    assign o_cfg_pend = r_cfg_pend;
    assign o_enable   = r_enable;

endmodule : spart_baud_gen
`default_nettype wire

// File: rtl/spart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spart_ctrl
//  Description : SPART glue: baud tick generation, round-robin arbitration of
//                two byte producers onto one transmitter, and a one-deep
//                receive holding register with sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_ctrl
    import spart_pkg::*;
#(
    parameter int unsigned      DIV_W       = c_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(c_DEFAULT_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             enable,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    input  logic             rda,
    input  logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_byte,
    input  logic             rx_ack,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             last_grant
);

    tx_state_t r_state;
    tx_state_t w_state_nxt;
    logic      w_grant;
    logic      w_grant_idx;
    logic      w_cfg_pend;
    logic      w_idle;

    assign w_idle = (r_state == ST_IDLE);

    spart_baud_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .i_cfg_wr   (cfg_wr),
        .i_cfg_div  (cfg_div),
        .i_idle     (w_idle),
        .o_cfg_pend (w_cfg_pend),
        .o_enable   (enable)
    );

    // Next-state and grant decision; a pending divisor blocks granting for
    // the cycle in which it is applied.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_idx = last_grant;
        case (r_state)
            ST_IDLE: begin
                if (!w_cfg_pend && (req0_valid || req1_valid)) begin
                    w_grant     = 1'b1;
                    w_grant_idx = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
                    w_state_nxt = ST_START;
                end
            end
            ST_START:   w_state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: if (tx_busy)  w_state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!tx_busy) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Registered handshake outputs; tx_data holds until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'hFF;
            last_grant <= 1'b1;
        end else begin
            req0_ready <= w_grant & ~w_grant_idx;
            req1_ready <= w_grant &  w_grant_idx;
            tx_start   <= (r_state == ST_START);
            if (w_grant) begin
                tx_data    <= w_grant_idx ? req1_data : req0_data;
                last_grant <= w_grant_idx;
            end
        end
    end

    // One-deep receive buffer; a simultaneous ack frees the slot for the
    // new byte, and setting overrun beats clearing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_byte  <= 8'hFF;
            overrun  <= 1'b0;
        end else begin
            if (rda) begin
                if (!rx_valid || rx_ack) begin
                    rx_byte  <= rx_data;
                    rx_valid <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (rda && rx_valid && !rx_ack) overrun <= 1'b1;
            else if (ovr_clr)               overrun <= 1'b0;
        end
    end

endmodule : spart_ctrl
`default_nettype wire
